// File: rtl/csa_accumulator.sv
// Sequential multi-operand adder: keeps the running total in carry-save form
// (one 3:2 compression per beat) and resolves once with a single carry-propagate add.
module csa_accumulator #(
    parameter int W     = 4,
    parameter int N_MAX = 16,
    localparam int RW   = W + $clog2(N_MAX),
    localparam int CW   = $clog2(N_MAX) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_sum,
    output logic [CW-1:0] out_count,
    output logic          out_ovf
);

    // state   | meaning
    // ACCUM   | accepting operands, compressing into the carry-save pair
    // RESOLVE | one-cycle carry-propagate add of S and C
    // DONE    | result presented, waiting for out_ready
    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [CW-1:0] N_MAX_C = CW'(N_MAX);

    state_t        state_q, state_d;
    logic [RW-1:0] s_q, s_d;
    logic [RW-1:0] c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [RW-1:0] out_sum_q, out_sum_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          out_ovf_q, out_ovf_d;

    logic [RW-1:0] x;
    logic [RW-1:0] maj;

    assign x   = {{(RW-W){1'b0}}, in_data};
    assign maj = (s_q & c_q) | (s_q & x) | (c_q & x);

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        unique case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    s_d = s_q ^ c_q ^ x;
                    c_d = {maj[RW-2:0], 1'b0};
                    if (cnt_q == N_MAX_C) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                out_sum_d   = s_q + c_q;
                out_count_d = cnt_q;
                out_ovf_d   = ovf_q;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Handshake flags come from the state alone so in_ready never loops back to in_valid.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
